// File: rtl/rlbp_pkg.sv
// rlbp_pkg -- shared definitions for the RLBP readout sequencer.
//   state_t      : sequencer FSM states
//   TG_*         : bit positions inside the one-hot transmission-gate bus,
//                  bus order {vref_cmp, ota_sh, cmp_out, sh_out, ota_out}
//   *_DEF        : default photodiode count, phase lengths, t_int width
//   cnt_width()  : width of the shared phase down-counter
//   tg_onehot()  : one-hot TG vector for a given TG bit position
package rlbp_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN,
    S_GAP,
    S_RST,
    S_INT,
    S_SH,
    S_CMP,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int TG_W        = 5;
  localparam int TG_OTA_OUT  = 0;
  localparam int TG_SH_OUT   = 1;
  localparam int TG_CMP_OUT  = 2;
  localparam int TG_OTA_SH   = 3;
  localparam int TG_VREF_CMP = 4;

  localparam int NPD_DEF   = 12;
  localparam int T_RST_DEF = 8;
  localparam int T_SH_DEF  = 4;
  localparam int T_CMP_DEF = 4;
  localparam int TW_DEF    = 16;

  // One counter serves every phase, so it must hold both the widest fixed
  // phase length and the full integration-time field.
  function automatic int cnt_width(input int tw, input int t_rst,
                                   input int t_sh, input int t_cmp);
    int t_max;
    int w;
    t_max = t_rst;
    if (t_sh > t_max) t_max = t_sh;
    if (t_cmp > t_max) t_max = t_cmp;
    w = (t_max > 1) ? $clog2(t_max) : 1;
    return (tw > w) ? tw : w;
  endfunction

  function automatic logic [TG_W-1:0] tg_onehot(input int bit_idx);
    return TG_W'(1) << bit_idx;
  endfunction

endpackage

// File: rtl/rlbp_sync2.sv
// rlbp_sync2 -- two-flop synchronizer for the asynchronous comparator output.
//   wb_clk_i : destination clock
//   wb_rst_i : synchronous active-high reset, clears both flops
//   d        : asynchronous input
//   q        : synchronized output (two cycles of latency)
module rlbp_sync2 (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments let meta and q update from pre-edge values,
  // giving two real flop stages; blocking here would collapse them into one.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rlbp_readout_seq.sv
// rlbp_readout_seq -- sequences one readout frame of the photodiode front end.
// For every enabled photodiode it selects the pd, runs reset -> integrate ->
// sample-hold -> compare with a one-cycle all-off gap before each phase, and
// captures the synchronized comparator bit into the frame code.
//   wb_clk_i, wb_rst_i      : clock, synchronous active-high reset
//   start, abort            : frame start request / immediate frame abort
//   t_int, pd_mask, side_b  : frame config, latched at start
//   vref_sel_i              : reference-select request (sampled only in IDLE)
//   cmp_i                   : asynchronous comparator output
//   sw1, sw2, sh, sh_cmp, sh_rst : analog phase switches
//   pd_a, pd_b              : one-hot photodiode select per side
//   tg_sel                  : one-hot TG controls {vref_cmp,ota_sh,cmp_out,sh_out,ota_out}
//   vref_sel_c              : registered reference select
//   busy, done              : frame in progress / one-cycle completion pulse
//   code                    : last completed frame result
//   idx                     : pixel currently being read
// Every output is a flop; next values are computed from the next state so the
// pins change cleanly on the clock edge. NPD must stay below 16 to fit idx.
module rlbp_readout_seq
  import rlbp_pkg::*;
#(
  parameter int NPD   = NPD_DEF,
  parameter int T_RST = T_RST_DEF,
  parameter int T_SH  = T_SH_DEF,
  parameter int T_CMP = T_CMP_DEF,
  parameter int TW    = TW_DEF
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            start,
  input  logic            abort,
  input  logic [TW-1:0]   t_int,
  input  logic [NPD-1:0]  pd_mask,
  input  logic            side_b,
  input  logic            vref_sel_i,
  input  logic            cmp_i,
  output logic            sw1,
  output logic            sw2,
  output logic            sh,
  output logic            sh_cmp,
  output logic            sh_rst,
  output logic [NPD-1:0]  pd_a,
  output logic [NPD-1:0]  pd_b,
  output logic [TG_W-1:0] tg_sel,
  output logic            vref_sel_c,
  output logic            busy,
  output logic            done,
  output logic [NPD-1:0]  code,
  output logic [3:0]      idx
);

  localparam int CW = cnt_width(TW, T_RST, T_SH, T_CMP);
  localparam int IW = 4;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_RST   = CW'(T_RST - 1);
  localparam logic [CW-1:0] CNT_SH    = CW'(T_SH - 1);
  localparam logic [CW-1:0] CNT_CMP   = CW'(T_CMP - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_END   = IW'(NPD);
  localparam logic [TW-1:0] TINT_MIN  = TW'(1);

  // Control state
  state_t         state_q, state_d;
  state_t         phase_q, phase_d;   // phase entered when the current GAP ends
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  t_int_q, t_int_d;
  logic [NPD-1:0] mask_q, mask_d;
  logic           side_q, side_d;
  logic [NPD-1:0] work_q, work_d;     // code being assembled this frame

  // Next values of the registered outputs
  logic            sw1_d, sw2_d, sh_d, sh_cmp_d, sh_rst_d;
  logic [NPD-1:0]  pd_a_d, pd_b_d, code_d;
  logic [TG_W-1:0] tg_d;
  logic            vref_d, busy_d, done_d;
  logic [IW-1:0]   idx_d;

  logic           cmp_sync;
  logic [NPD-1:0] pd_sel;

  rlbp_sync2 u_sync (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .d        (cmp_i),
    .q        (cmp_sync)
  );

  assign pd_sel = NPD'(1) << idx;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    t_int_d = t_int_q;
    mask_d  = mask_q;
    side_d  = side_q;
    work_d  = work_q;
    pd_a_d  = pd_a;
    pd_b_d  = pd_b;
    code_d  = code;
    vref_d  = vref_sel_c;
    busy_d  = busy;
    done_d  = 1'b0;
    idx_d   = idx;

    unique case (state_q)
      S_IDLE: begin
        vref_d = vref_sel_i;
        if (start && !abort) begin
          t_int_d = (t_int == '0) ? TINT_MIN : t_int;
          mask_d  = pd_mask;
          side_d  = side_b;
          work_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (idx >= IDX_END) begin
          code_d  = work_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (!mask_q[idx]) begin
          work_d[idx] = 1'b0;
          idx_d       = idx + IDX_ONE;
        end else begin
          if (side_q) pd_b_d = pd_sel;
          else        pd_a_d = pd_sel;
          phase_d = S_RST;
          state_d = S_GAP;
        end
      end

      // Load the counter for the phase that follows; the gap itself is one cycle.
      S_GAP: begin
        state_d = phase_q;
        unique case (phase_q)
          S_RST:   cnt_d = CNT_RST;
          S_INT:   cnt_d = CW'(t_int_q) - CNT_ONE;
          S_SH:    cnt_d = CNT_SH;
          default: cnt_d = CNT_CMP;
        endcase
      end

      S_RST: begin
        if (cnt_q == '0) begin
          phase_d = S_INT;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_INT: begin
        if (cnt_q == '0) begin
          phase_d = S_SH;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_SH: begin
        if (cnt_q == '0) begin
          phase_d = S_CMP;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      // The last compare cycle is the latest sample, giving the comparator and
      // the synchronizer the full phase to settle.
      S_CMP: begin
        if (cnt_q == '0) begin
          work_d[idx] = cmp_sync;
          pd_a_d      = '0;
          pd_b_d      = '0;
          state_d     = S_NEXT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_NEXT: begin
        idx_d   = idx + IDX_ONE;
        state_d = S_SCAN;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort drops straight back to the reset picture but keeps the last code.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      pd_a_d  = '0;
      pd_b_d  = '0;
      vref_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      idx_d   = '0;
    end

    // Phase switches and TG select follow the state being entered.
    sw1_d    = 1'b0;
    sw2_d    = 1'b0;
    sh_d     = 1'b0;
    sh_cmp_d = 1'b0;
    sh_rst_d = 1'b0;
    tg_d     = tg_onehot(TG_OTA_OUT);
    unique case (state_d)
      S_RST: begin
        sh_rst_d = 1'b1;
        sw1_d    = 1'b1;
      end
      S_INT:   sw2_d = 1'b1;
      S_SH: begin
        sh_d = 1'b1;
        tg_d = tg_onehot(TG_OTA_SH);
      end
      S_CMP: begin
        sh_cmp_d = 1'b1;
        tg_d     = tg_onehot(TG_VREF_CMP);
      end
      S_DONE:  tg_d = tg_onehot(TG_SH_OUT);
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      phase_q    <= S_RST;
      cnt_q      <= '0;
      t_int_q    <= TINT_MIN;
      mask_q     <= '0;
      side_q     <= 1'b0;
      work_q     <= '0;
      sw1        <= 1'b0;
      sw2        <= 1'b0;
      sh         <= 1'b0;
      sh_cmp     <= 1'b0;
      sh_rst     <= 1'b0;
      pd_a       <= '0;
      pd_b       <= '0;
      tg_sel     <= tg_onehot(TG_OTA_OUT);
      vref_sel_c <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      code       <= '0;
      idx        <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      t_int_q    <= t_int_d;
      mask_q     <= mask_d;
      side_q     <= side_d;
      work_q     <= work_d;
      sw1        <= sw1_d;
      sw2        <= sw2_d;
      sh         <= sh_d;
      sh_cmp     <= sh_cmp_d;
      sh_rst     <= sh_rst_d;
      pd_a       <= pd_a_d;
      pd_b       <= pd_b_d;
      tg_sel     <= tg_d;
      vref_sel_c <= vref_d;
      busy       <= busy_d;
      done       <= done_d;
      code       <= code_d;
      idx        <= idx_d;
    end
  end

endmodule

// File: tb/tb_rlbp_readout_seq.sv
// tb_rlbp_readout_seq -- scoreboard bench for rlbp_readout_seq.
// Stimulus pushes the expected frame result (code, start-to-done latency and
// the set of pd bits that should light up) into a queue; a monitor pops and
// compares on every done pulse and also watches the analog sequencing rules
// on every cycle.
module tb_rlbp_readout_seq;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        start;
  logic        abort;
  logic [15:0] t_int;
  logic [11:0] pd_mask;
  logic        side_b;
  logic        vref_sel_i;
  logic        cmp_i;
  logic        sw1, sw2, sh, sh_cmp, sh_rst;
  logic [11:0] pd_a, pd_b;
  logic [4:0]  tg_sel;
  logic        vref_sel_c;
  logic        busy;
  logic        done;
  logic [11:0] code;
  logic [3:0]  idx;

  typedef struct {
    logic [11:0] code;
    int          lat;
    int          start_cyc;
    logic [11:0] a_seen;
    logic [11:0] b_seen;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cmp_mode = 0;   // 0: cmp high on even idx, 1: cmp constant high

  rlbp_readout_seq dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .start      (start),
    .abort      (abort),
    .t_int      (t_int),
    .pd_mask    (pd_mask),
    .side_b     (side_b),
    .vref_sel_i (vref_sel_i),
    .cmp_i      (cmp_i),
    .sw1        (sw1),
    .sw2        (sw2),
    .sh         (sh),
    .sh_cmp     (sh_cmp),
    .sh_rst     (sh_rst),
    .pd_a       (pd_a),
    .pd_b       (pd_b),
    .tg_sel     (tg_sel),
    .vref_sel_c (vref_sel_c),
    .busy       (busy),
    .done       (done),
    .code       (code),
    .idx        (idx)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Comparator model: an analog bit chosen from the pixel under test.
  initial begin
    cmp_i = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      cmp_i = (cmp_mode == 0) ? ~idx[0] : 1'b1;
    end
  end

  task automatic start_frame(input logic [11:0] mask, input logic side, input logic [15:0] tint,
                             input bit push, input logic [11:0] e_code, input int e_lat,
                             input logic [11:0] e_a, input logic [11:0] e_b);
    exp_t e;
    @(negedge wb_clk_i);
    pd_mask = mask;
    side_b  = side;
    t_int   = tint;
    start   = 1'b1;
    if (push) begin
      e.code      = e_code;
      e.lat       = e_lat;
      e.start_cyc = cyc;
      e.a_seen    = e_a;
      e.b_seen    = e_b;
      sb_q.push_back(e);
    end
    @(negedge wb_clk_i);
    start = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge wb_clk_i);
    check("frame_complete", sb_q.size(), 0);
    if (sb_q.size() != 0) sb_q.delete();
  endtask

  // Monitor: sequencing rules every cycle, scoreboard compare on done.
  logic        busy_prev, done_prev;
  logic [11:0] acc_a, acc_b;
  int          last_cur, zero_run;

  initial begin : monitor
    exp_t e;
    int   n_on;
    int   cur;
    busy_prev = 1'b0;
    done_prev = 1'b0;
    acc_a     = '0;
    acc_b     = '0;
    last_cur  = 0;
    zero_run  = 0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
        busy_prev = 1'b0;
        done_prev = 1'b0;
        acc_a     = '0;
        acc_b     = '0;
        last_cur  = 0;
        zero_run  = 0;
      end else begin
        if (busy && !busy_prev) begin
          acc_a = '0;
          acc_b = '0;
        end
        acc_a |= pd_a;
        acc_b |= pd_b;

        check("tg_onehot", 32'($onehot(tg_sel)), 1);
        if (busy) begin
          n_on = int'(sw1) + int'(sw2) + int'(sh) + int'(sh_cmp);
          check("bbm_overlap", 32'(n_on <= 1), 1);
          check("pd_onehot0", 32'($onehot0(pd_a | pd_b) && !((pd_a != 0) && (pd_b != 0))), 1);
        end

        cur = sh_rst ? 1 : sw2 ? 2 : sh ? 3 : sh_cmp ? 4 : 0;
        if ((pd_a | pd_b) == '0) begin
          last_cur = 0;
          zero_run = 0;
        end else begin
          if (cur == 0) begin
            zero_run++;
          end else if (cur != last_cur) begin
            check("gap_len", 32'(zero_run), 1);
            zero_run = 0;
          end
          last_cur = cur;
        end

        if (done_prev) check("done_pulse_width", 32'(done), 0);
        if (done) begin
          check("done_expected", 32'(sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("frame_code", 32'(code), 32'(e.code));
            check("frame_latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            check("pd_a_seen", 32'(acc_a), 32'(e.a_seen));
            check("pd_b_seen", 32'(acc_b), 32'(e.b_seen));
            check("busy_at_done", 32'(busy), 0);
            check("tg_at_done", 32'(tg_sel), 32'h02);
          end
        end
        busy_prev = busy;
        done_prev = done;
      end
    end
  end

  initial begin : stimulus
    bit found;
    bit saw_done;
    wb_rst_i   = 1'b1;
    start      = 1'b1;
    abort      = 1'b0;
    t_int      = 16'd10;
    pd_mask    = 12'hFFF;
    side_b     = 1'b0;
    vref_sel_i = 1'b1;

    // Reset held with start and vref requested: neither may take effect.
    repeat (3) @(negedge wb_clk_i);
    check("rst_hold_busy", 32'(busy), 0);
    check("rst_hold_vref", 32'(vref_sel_c), 0);
    check("rst_hold_tg", 32'(tg_sel), 32'h01);
    wb_rst_i   = 1'b0;
    start      = 1'b0;
    vref_sel_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_switches", 32'({sw1, sw2, sh, sh_cmp, sh_rst}), 0);
    check("rst_pd", 32'({pd_a, pd_b}), 0);
    check("rst_tg", 32'(tg_sel), 32'h01);
    check("rst_busy_done", 32'({busy, done}), 0);
    check("rst_code", 32'(code), 0);
    check("rst_idx", 32'(idx), 0);

    // Full frame: 12 pixels x 32 cycles + final scan + done.
    cmp_mode = 0;
    start_frame(12'hFFF, 1'b0, 16'd10, 1'b1, 12'h555, 386, 12'hFFF, 12'h000);
    wait_frame(600);

    // vref follows the request in IDLE, holds mid-frame, clears on abort.
    vref_sel_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    check("vref_idle_update", 32'(vref_sel_c), 1);
    start_frame(12'hFFF, 1'b0, 16'd10, 1'b0, 12'h000, 0, 12'h000, 12'h000);
    vref_sel_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge wb_clk_i);
      if (idx == 4'd5 && sw2) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reach_int5", 32'(found), 1);
    check("vref_hold_midframe", 32'(vref_sel_c), 1);
    abort = 1'b1;
    @(negedge wb_clk_i);
    abort = 1'b0;
    check("abort_switches", 32'({sw1, sw2, sh, sh_cmp, sh_rst}), 0);
    check("abort_pd", 32'({pd_a, pd_b}), 0);
    check("abort_tg", 32'(tg_sel), 32'h01);
    check("abort_busy_done", 32'({busy, done}), 0);
    check("abort_vref", 32'(vref_sel_c), 0);
    check("abort_idx", 32'(idx), 0);
    check("abort_code_held", 32'(code), 32'h555);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i);
      saw_done |= done;
    end
    check("abort_no_done", 32'(saw_done), 0);

    // Masked frame on side b: two pixels at 25 cycles, ten skips at 1 cycle.
    cmp_mode = 1;
    start_frame(12'h081, 1'b1, 16'd3, 1'b1, 12'h081, 62, 12'h000, 12'h081);
    wait_frame(200);

    // Reset mid-frame clears everything including the code.
    start_frame(12'hFFF, 1'b0, 16'd10, 1'b0, 12'h000, 0, 12'h000, 12'h000);
    repeat (40) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("midrst_code", 32'(code), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_pd_sw", 32'({pd_a, pd_b, sw1, sw2, sh, sh_cmp, sh_rst}), 0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // t_int=0 runs as 1; a start with new config mid-frame is ignored.
    start_frame(12'h001, 1'b0, 16'd0, 1'b1, 12'h001, 36, 12'h001, 12'h000);
    repeat (5) @(negedge wb_clk_i);
    start   = 1'b1;
    pd_mask = 12'hFFF;
    t_int   = 16'd50;
    side_b  = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    wait_frame(200);

    // Empty mask: no analog activity, done NPD+2 cycles after start.
    start_frame(12'h000, 1'b0, 16'd10, 1'b1, 12'h000, 14, 12'h000, 12'h000);
    wait_frame(100);

    repeat (3) @(negedge wb_clk_i);
    check("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rlbp_readout_seq.md
Name: rlbp_readout_seq

Overview:
- Sequences one readout frame of the 12-photodiode analog front end.
- For each enabled photodiode it selects the pd pair, drives the phases reset → integrate → sample-hold → compare, sets the one-hot transmission-gate controls, and captures the comparator bit.
- Sits inside rlbp_macro, between its register file (start, config) and the analog SystemLevel control pins.
- Produces a 12-bit binary code per frame.

Parameters:
- NPD, 12, number of photodiodes/bits in the code.
- T_RST, 8, reset-phase length in cycles (≥1).
- T_SH, 4, sample-hold phase length in cycles (≥1).
- T_CMP, 4, compare phase length in cycles (≥3, covers the 2-FF sync).
- TW, 16, width of the integration-time field.

Ports:
- wb_clk_i in 1: the block's one clock.
- wb_rst_i in 1: synchronous reset, active-high.
- start in 1: one-cycle frame start request.
- abort in 1: terminate the frame immediately.
- t_int in TW: integration cycles, latched at start.
- pd_mask in NPD: enabled photodiodes, latched at start.
- side_b in 1: 0 selects pd_a, 1 selects pd_b; latched at start.
- vref_sel_i in 1: reference-select request.
- cmp_i in 1: comparator output from the analog macro (asynchronous).
- sw1, sw2, sh, sh_cmp, sh_rst out 1 each: analog phase switches.
- pd_a, pd_b out NPD each: one-hot photodiode select.
- tg_sel out 5: one-hot TG controls, bit order {vref_cmp, ota_sh, cmp_out, sh_out, ota_out}.
- vref_sel_c out 1: registered vref_sel_i, updated only in IDLE.
- busy out 1: frame in progress.
- done out 1: one-cycle pulse, frame complete.
- code out NPD: last frame result.
- idx out 4: pixel currently being read.

Behaviour:
- Reset values:
  - All switch outputs 0; pd_a/pd_b 0; tg_sel 5'b00001; vref_sel_c 0.
  - busy 0, done 0, code 0, idx 0, state IDLE.
  - The 2-FF cmp synchronizer is cleared.
- All outputs are registered. No output glitches. tg_sel is always exactly one-hot.
- States: IDLE, SCAN, GAP, RST, INT, SH, CMP, NEXT, DONE.
- IDLE:
  - start=1 latches t_int (0 is treated as 1), pd_mask and side_b.
  - Clears the working code, sets idx=0 and busy=1, then enters SCAN.
- SCAN:
  - If idx ≥ NPD → DONE.
  - Else if pd_mask[idx]=0: working bit forced to 0, idx+1, stay in SCAN (1 cycle per skipped pixel).
  - Else assert pd_a[idx] or pd_b[idx] per side_b and enter GAP (next phase = RST).
- GAP:
  - Exactly 1 cycle with sw1, sw2, sh, sh_cmp, sh_rst all 0 (break-before-make).
  - Entered before every RST, INT, SH and CMP phase.
  - pd select stays held throughout.
- Phase outputs:
  - RST (T_RST cycles): sh_rst=1, sw1=1; tg=ota_out.
  - INT (t_int cycles): sw2=1; tg=ota_out.
  - SH (T_SH cycles): sh=1; tg=ota_sh.
  - CMP (T_CMP cycles): sh_cmp=1; tg=vref_cmp.
- CMP sampling:
  - On the last CMP cycle, the synchronized cmp bit is written to working code[idx].
- NEXT (1 cycle): pd select cleared, idx+1, → SCAN.
- Per enabled pixel: 1 (SCAN) + 4 (GAPs) + T_RST + t_int + T_SH + T_CMP + 1 (NEXT) cycles.
- DONE (1 cycle):
  - code ← working code; done=1; tg=sh_out; busy=0; → IDLE.
  - start is accepted the following cycle.
- Phase counter: a single down-counter, width max(TW, clog2(max T)). It is loaded with length−1 on phase entry, and the phase ends when it reaches 0.
- start while busy is ignored. Config inputs changing mid-frame have no effect.
- abort (any non-IDLE state): next cycle → IDLE with every output at its reset value except code, which holds the previous frame. No done pulse. abort and start in the same IDLE cycle: abort wins (no start).
- wb_rst_i mid-frame: identical to the reset values, code cleared.
- All-zero pd_mask: no analog activity; done is asserted NPD+2 cycles after start, code=0.

Decomposition:
- Package rlbp_pkg holds:
  - the state enum;
  - TG bit-index constants (TG_OTA_OUT=0 … TG_VREF_CMP=4);
  - the default phase lengths.
- One sub-module, rlbp_sync2: the 2-FF synchronizer for cmp_i with synchronous reset.

Test Plan:
- Reset check: after wb_rst_i, all switches 0, tg_sel=00001, busy=0, code=0; start ignored while reset is held.
- Full frame:
  - Stimulus: mask=12'hFFF, side_b=0, t_int=10, cmp_i driven =1 for even idx.
  - Expected: code=12'h555.
  - Expected: done exactly 12×(1+4+8+10+4+4+1)+NPD-scan+DONE offset cycles after start, matching the formula; only pd_a toggles.
- Masked frame:
  - Stimulus: mask=12'h081, side_b=1, cmp_i=1 constant.
  - Expected: code=12'h081; pd_b pulses only bits 0 and 7; skipped pixels cost 1 cycle each.
- Break-before-make: monitor every cycle of a frame → never two of sw1/sw2/sh/sh_cmp asserted together; exactly 1 all-zero cycle between phases; tg_sel always one-hot.
- Abort mid-INT of pixel 5 → the next cycle all outputs are at reset values, code is unchanged from the prior frame, no done; a new start then runs normally.
- Edge cases:
  - t_int=0 behaves as 1.
  - start while busy is ignored.
  - mask=0 gives done 14 cycles after start with code=0.
